// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data-memory port between fetch (IF) and load/store (LS)
//
// Purpose:
//   Serialises IF and LS memory transactions onto a single variable-latency
//   memory port. Address/we/wdata are latched at grant. The owner receives a
//   one-cycle ack together with registered read data.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   if_req/if_addr                fetch request (level, held until if_ack) and address
//   if_rdata/if_ack               fetch read data and one-cycle completion pulse
//   ls_req/ls_we/ls_addr/ls_wdata load/store request, store enable, address, store data
//   ls_rdata/ls_ack               load data (0 for stores) and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory request (held until mem_ready) and latched command
//   mem_rdata/mem_ready           memory read data and completion strobe
//   timeout_err                   sticky timeout flag
//
// Configuration:
//   ARB_TIMEOUT_EN  when defined, a BUSY phase lasting TIMEOUT_CYCLES cycles without
//                   mem_ready is abandoned: the owner is acked with rdata = 0 and
//                   timeout_err is set until reset. When undefined, BUSY waits
//                   indefinitely and timeout_err is tied to 0.

module dmem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dmem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t state;
    state_t state_nxt;

    logic                  owner;       // port that holds the current transaction
    logic                  last_grant;  // port granted most recently (round-robin pointer)
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] ls_rdata_q;

    logic                  grant_any;
    logic                  grant_ls;
    logic                  to_hit;      // BUSY abandoned this cycle because of timeout
    logic                  completing;  // BUSY ends this cycle (normal or timeout)
    logic [DATA_WIDTH-1:0] resp_data;

    // ------------------------------------------------------------------
    // Grant decision: a lone requester wins; on contention the port that
    // did not win last time gets the grant.
    // ------------------------------------------------------------------
    always_comb begin
        grant_any = if_req | ls_req;
        if (if_req && ls_req) begin
            grant_ls = (last_grant == OWN_IF);
        end else begin
            grant_ls = ls_req;
        end
    end

    // ------------------------------------------------------------------
    // Optional timeout. The counter is cleared while IDLE, so it is always
    // zero on entry to BUSY. to_hit fires in the TIMEOUT_CYCLES-th BUSY
    // cycle without mem_ready; mem_ready in that same cycle wins.
    // ------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             timeout_err_q;

    assign to_hit = (state == S_BUSY) && !mem_ready && (to_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == S_IDLE) begin
            to_cnt <= '0;
        end else if ((state == S_BUSY) && !mem_ready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else if (to_hit) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign completing = (state == S_BUSY) && (mem_ready || to_hit);

    // Stores and timeouts return zero; loads return the memory data.
    assign resp_data = (mem_ready && !we_q) ? mem_rdata : '0;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any)  state_nxt = S_BUSY;
            S_BUSY:  if (completing) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the registered state, so an asynchronous
    // reset clears mem_req and both acks immediately.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req = 1'b0;
        if_ack  = 1'b0;
        ls_ack  = 1'b0;
        case (state)
            S_BUSY: mem_req = 1'b1;
            S_RESP: begin
                if_ack = (owner == OWN_IF);
                ls_ack = (owner == OWN_LS);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command latch at grant, response capture at completion.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_IF;
            last_grant <= OWN_LS;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if ((state == S_IDLE) && grant_any) begin
                owner      <= grant_ls;
                last_grant <= grant_ls;
                addr_q     <= grant_ls ? ls_addr : if_addr;
                we_q       <= grant_ls & ls_we;
                wdata_q    <= grant_ls ? ls_wdata : '0;
            end
            if (completing) begin
                if (owner == OWN_LS) begin
                    ls_rdata_q <= resp_data;
                end else begin
                    if_rdata_q <= resp_data;
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        timeout_err;

    int n_pass;
    int n_total;

    dmem_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_rdata    (ls_rdata),
        .ls_ack      (ls_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge; inputs are driven and
    // outputs (all decoded from registers) are sampled at this point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_addr   = '0;
        ls_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        step();
        step();

        // ---- reset state ----
        check("rst_mem_req", mem_req, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_ls_ack", ls_ack, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;

        // ---- single fetch, memory answers two cycles after mem_req ----
        step();                                   // cycle 0: IDLE
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        check("t1_c0_mem_req", mem_req, 0);
        step();                                   // cycle 1: BUSY
        check("t1_c1_mem_req", mem_req, 1);
        check("t1_c1_mem_addr", mem_addr, 32'h10);
        check("t1_c1_mem_we", mem_we, 0);
        step();                                   // cycle 2: BUSY
        check("t1_c2_if_ack", if_ack, 0);
        step();                                   // cycle 3: BUSY, ready
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        check("t1_c3_mem_req", mem_req, 1);
        step();                                   // cycle 4: RESP
        mem_ready = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        check("t1_c4_if_ack", if_ack, 1);
        check("t1_c4_if_rdata", if_rdata, 32'h0050_0093);
        check("t1_c4_ls_ack", ls_ack, 0);
        check("t1_c4_mem_req", mem_req, 0);
        step();                                   // cycle 5: IDLE
        if_req = 1'b0;
        check("t1_c5_if_ack", if_ack, 0);
        check("t1_c5_if_rdata_hold", if_rdata, 32'h0050_0093);
        step();
        check("t1_c6_mem_req", mem_req, 0);

        // ---- contention from reset: strict IF, LS, IF, LS ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0200;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_addr   = 32'h0000_0300;
        mem_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            mem_rdata = 32'h0000_1000 + 32'(g);
            step();                               // BUSY
            check($sformatf("t2_g%0d_mem_addr", g), mem_addr,
                  (g % 2 == 0) ? 32'h200 : 32'h300);
            step();                               // RESP
            check($sformatf("t2_g%0d_if_ack", g), if_ack, (g % 2 == 0) ? 1 : 0);
            check($sformatf("t2_g%0d_ls_ack", g), ls_ack, (g % 2 == 1) ? 1 : 0);
            step();                               // IDLE
        end
        if_req    = 1'b0;
        ls_req    = 1'b0;
        mem_ready = 1'b0;
        check("t2_ls_rdata_last", ls_rdata, 32'h0000_1003);
        check("t2_if_rdata_last", if_rdata, 32'h0000_1002);
        step();

        // ---- zero-wait store ----
        ls_req    = 1'b1;
        ls_we     = 1'b1;
        ls_addr   = 32'h0000_0100;
        ls_wdata  = 32'hDEAD_BEEF;
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();                                   // cycle 1: BUSY
        check("t3_c1_mem_we", mem_we, 1);
        check("t3_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t3_c1_mem_addr", mem_addr, 32'h100);
        step();                                   // cycle 2: RESP
        check("t3_c2_ls_ack", ls_ack, 1);
        check("t3_c2_ls_rdata", ls_rdata, 0);
        check("t3_c2_if_ack", if_ack, 0);
        step();                                   // cycle 3: IDLE
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        mem_ready = 1'b0;
        check("t3_c3_ls_ack", ls_ack, 0);
        step();

        // ---- reset in BUSY, then pending IF granted first ----
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        step();                                   // BUSY owner IF
        ls_req  = 1'b1;
        ls_addr = 32'h0000_0080;
        check("t4_busy_mem_req", mem_req, 1);
        step();
        rst = 1'b1;
        #1;
        check("t4_async_mem_req", mem_req, 0);
        check("t4_async_if_ack", if_ack, 0);
        check("t4_async_ls_ack", ls_ack, 0);
        step();
        rst = 1'b0;
        step();                                   // IDLE saw both -> BUSY
        check("t4_regrant_mem_addr", mem_addr, 32'h40);
        check("t4_regrant_mem_req", mem_req, 1);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0055;
        step();                                   // RESP
        mem_ready = 1'b0;
        check("t4_regrant_if_ack", if_ack, 1);
        step();                                   // IDLE
        if_req = 1'b0;

        // ---- ls_addr changed while BUSY ----
        step();                                   // BUSY owner LS
        check("t5_mem_addr", mem_addr, 32'h80);
        ls_addr = 32'h0000_00C0;
        step();
        check("t5_mem_addr_held", mem_addr, 32'h80);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0077;
        step();                                   // RESP
        check("t5_ls_ack", ls_ack, 1);
        check("t5_ls_rdata", ls_rdata, 32'h77);
        ls_req    = 1'b0;
        mem_ready = 1'b0;
        step();
        step();

        // ---- memory never answers ----
        if_req  = 1'b1;
        if_addr = 32'h0000_0020;
        step();                                   // BUSY cycle 1
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("t6_busy%0d_mem_req", i), mem_req, 1);
            step();
        end
`ifdef ARB_TIMEOUT_EN
        check("t6_to_mem_req", mem_req, 0);
        check("t6_to_if_ack", if_ack, 1);
        check("t6_to_if_rdata", if_rdata, 0);
        check("t6_to_err", timeout_err, 1);
        step();
        if_req = 1'b0;
        check("t6_to_ack_pulse", if_ack, 0);
        step();
        step();
        check("t6_to_err_sticky", timeout_err, 1);
        rst = 1'b1;
        #1;
        check("t6_to_err_cleared", timeout_err, 0);
        step();
        rst = 1'b0;
`else
        check("t6_wait_mem_req", mem_req, 1);
        check("t6_wait_err", timeout_err, 0);
        check("t6_wait_if_ack", if_ack, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0099;
        step();
        mem_ready = 1'b0;
        check("t6_late_if_ack", if_ack, 1);
        check("t6_late_if_rdata", if_rdata, 32'h99);
        step();
        if_req = 1'b0;
        check("t6_late_err", timeout_err, 0);
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
